// File: rtl/baby_vga_pkg.sv
// Shared constants, bank layout and output packing for the baby VGA pixel stage.
`timescale 1ns/1ps
package baby_vga_pkg;

   localparam int NUM_ROWS    = 8;
   localparam int ROW_W       = 8;
   localparam int COL_W       = 6;
   localparam int CTRL_W      = 2;
   localparam int ADDR_W      = 4;
   localparam int PIPE_STAGES = 2;

   // ctrl bit positions
   localparam int CTRL_EN  = 0;
   localparam int CTRL_INV = 1;

   // register map: rows occupy 0..ADDR_ROW_LAST, anything above ADDR_CTRL is a hole
   localparam logic [ADDR_W-1:0] ADDR_ROW_LAST = 4'd7;
   localparam logic [ADDR_W-1:0] ADDR_FG       = 4'd8;
   localparam logic [ADDR_W-1:0] ADDR_BG       = 4'd9;
   localparam logic [ADDR_W-1:0] ADDR_CTRL     = 4'd10;

   localparam logic [COL_W-1:0]  FG_RST   = 6'h3F;
   localparam logic [COL_W-1:0]  BG_RST   = 6'h00;
   localparam logic [CTRL_W-1:0] CTRL_RST = 2'b01;

   // colour is {B[1:0],G[1:0],R[1:0]}
   typedef struct packed {
      logic [NUM_ROWS-1:0][ROW_W-1:0] rows;
      logic [COL_W-1:0]               fg;
      logic [COL_W-1:0]               bg;
      logic [CTRL_W-1:0]              ctrl;
   } bank_t;

   localparam bank_t BANK_RST = '{rows: '0, fg: FG_RST, bg: BG_RST, ctrl: CTRL_RST};

   // output byte is {hsync, B0, G0, R0, vsync, B1, G1, R1}
   function automatic logic [7:0] pack_vga(input logic hs, input logic vs,
                                           input logic [COL_W-1:0] c);
      return {hs, c[4], c[2], c[0], vs, c[5], c[3], c[1]};
   endfunction

endpackage

// File: rtl/baby_vga_regbank.sv
// Double-buffered register bank: writes land in shadow, whole bank moves to
// active on a frame edge so a frame never shows a half-updated pattern.
`timescale 1ns/1ps
module baby_vga_regbank
   import baby_vga_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [7:0]        i_wr_data,
   input  logic              i_frame_edge,
   output bank_t             o_active,
   output logic              o_pending
);

   bank_t r_shadow;
   bank_t r_active;
   bank_t w_shadow_nxt;
   logic  r_pending;
   logic  w_wr_ok;
   logic  w_copy;

   assign w_wr_ok = i_wr_en && (i_wr_addr <= ADDR_CTRL);
   assign w_copy  = i_frame_edge && r_pending;

   // decode the write into the next shadow value; unused data bits are dropped
   always_comb begin
      w_shadow_nxt = r_shadow;
      if (w_wr_ok) begin
         if (i_wr_addr <= ADDR_ROW_LAST)
            w_shadow_nxt.rows[i_wr_addr[2:0]] = i_wr_data;
         else if (i_wr_addr == ADDR_FG)
            w_shadow_nxt.fg = i_wr_data[COL_W-1:0];
         else if (i_wr_addr == ADDR_BG)
            w_shadow_nxt.bg = i_wr_data[COL_W-1:0];
         else
            w_shadow_nxt.ctrl = i_wr_data[CTRL_W-1:0];
      end
   end

   // shadow bank takes host writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_shadow <= BANK_RST;
      else        r_shadow <= w_shadow_nxt;
   end

   // active bank copies the pre-write shadow on a frame edge with work pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_active <= BANK_RST;
      else if (w_copy) r_active <= r_shadow;
   end

   // a write on the copy edge keeps pending set so it goes out next frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_pending <= 1'b0;
      else if (w_wr_ok) r_pending <= 1'b1;
      else if (w_copy)  r_pending <= 1'b0;
   end

   assign o_active  = r_active;
   assign o_pending = r_pending;

endmodule

// File: rtl/baby_vga_pixel.sv
// Pixel colour stage: 8x8 pattern lookup into fg/bg colour, two-cycle pipeline
// with syncs delayed alongside the colour.
`timescale 1ns/1ps
module baby_vga_pixel
   import baby_vga_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [5:0]        x_hi,
   input  logic [4:0]        x_lo,
   input  logic [4:0]        y_hi,
   input  logic [5:0]        y_lo,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              blank_in,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   output logic [7:0]        vga_out,
   output logic              pending
);

   bank_t            w_active;
   logic             w_frame_edge;
   logic [ROW_W-1:0] w_row;
   logic [2:0]       w_bit_idx;
   logic             w_bit;
   logic [COL_W-1:0] w_colour;
   logic [15:0]      w_unused_pos;

   logic             r_s1_bit;
   logic             r_s1_blank;
   logic             r_s1_hsync;
   logic             r_s1_vsync;
   logic [7:0]       r_vga;

   // only the cell index bits matter; within-cell offsets and upper repeats are ignored
   assign w_unused_pos = {x_hi[5:3], x_lo, y_hi[4:3], y_lo};

   // stage-1 vsync doubles as the registered copy for edge detect
   assign w_frame_edge = vsync_in && !r_s1_vsync;

   baby_vga_regbank u_regbank (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_wr_en      (wr_en),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .i_frame_edge (w_frame_edge),
      .o_active     (w_active),
      .o_pending    (pending)
   );

   // leftmost pixel of a cell maps to the row's MSB
   assign w_row     = w_active.rows[y_hi[2:0]];
   assign w_bit_idx = 3'd7 - x_hi[2:0];
   assign w_bit     = w_row[w_bit_idx];

   // stage 1: pattern bit with its blank and sync levels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_bit   <= 1'b0;
         r_s1_blank <= 1'b0;
         r_s1_hsync <= 1'b0;
         r_s1_vsync <= 1'b0;
      end else begin
         r_s1_bit   <= w_bit;
         r_s1_blank <= blank_in;
         r_s1_hsync <= hsync_in;
         r_s1_vsync <= vsync_in;
      end
   end

   // colour select: blank or disabled forces black, otherwise bit^invert picks fg
   always_comb begin
      w_colour = '0;
      if (!r_s1_blank && w_active.ctrl[CTRL_EN])
         w_colour = (r_s1_bit ^ w_active.ctrl[CTRL_INV]) ? w_active.fg : w_active.bg;
   end

   // stage 2: packed colour and syncs to the pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_vga <= 8'h00;
      else        r_vga <= pack_vga(r_s1_hsync, r_s1_vsync, w_colour);
   end

   assign vga_out = r_vga;

endmodule

// File: tb/tb_baby_vga_pixel.sv
// Directed bench for baby_vga_pixel: expected pixels queued at drive time,
// popped two clocks later when the DUT presents them.
`timescale 1ns/1ps
module tb_baby_vga_pixel;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] x_hi;
   logic [4:0] x_lo;
   logic [4:0] y_hi;
   logic [5:0] y_lo;
   logic       hsync_in, vsync_in, blank_in;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] vga_out;
   logic       pending;

   int         checks = 0;
   int         errors = 0;
   int         pix_id = 0;
   logic [7:0] exp_q[$];
   int         tag_q[$];

   always #8 clk = ~clk;

   baby_vga_pixel dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .x_hi     (x_hi),
      .x_lo     (x_lo),
      .y_hi     (y_hi),
      .y_lo     (y_lo),
      .hsync_in (hsync_in),
      .vsync_in (vsync_in),
      .blank_in (blank_in),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .vga_out  (vga_out),
      .pending  (pending)
   );

   // spec bit order {hsync, B0, G0, R0, vsync, B1, G1, R1}, colour {B,G,R}
   function automatic logic [7:0] exp_vga(input logic hs, input logic vs, input logic [5:0] c);
      logic [1:0] b, g, r;
      b = c[5:4]; g = c[3:2]; r = c[1:0];
      return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
   endfunction

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_pend(input string tag, input logic exp);
      checks++;
      assert (pending === exp) else begin
         errors++;
         $error("FAIL %s observed pending=%b expected=%b", tag, pending, exp);
      end
   endtask

   // one pixel clock: check the matured entry, then drive the next pixel (and optional write)
   task automatic step(input logic [5:0] xh, input logic [4:0] yh, input logic hs,
                       input logic vs, input logic bl, input logic [5:0] col,
                       input logic we = 1'b0, input logic [3:0] wa = 4'd0,
                       input logic [7:0] wd = 8'h00);
      @(negedge clk);
      if (exp_q.size() == 2) begin
         logic [7:0] e;
         int         t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk8($sformatf("pix%0d", t), vga_out, e);
      end
      x_hi     = xh;
      y_hi     = yh;
      x_lo     = 5'($urandom);
      y_lo     = 6'($urandom);
      hsync_in = hs;
      vsync_in = vs;
      blank_in = bl;
      wr_en    = we;
      wr_addr  = wa;
      wr_data  = wd;
      exp_q.push_back(exp_vga(hs, vs, col));
      tag_q.push_back(pix_id);
      pix_id++;
   endtask

   initial begin
      rst_n = 1'b0;
      x_hi = '0; x_lo = '0; y_hi = '0; y_lo = '0;
      hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      #40;
      chk8("rst_vga", vga_out, 8'h00);
      chk_pend("rst_pend", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // row0 = 80, apply at frame edge, fg 3F at x_hi=0, bg at x_hi=1
      step(0, 0, 0, 0, 1, 6'h00, 1'b1, 4'd0, 8'h80);
      step(0, 0, 1, 0, 1, 6'h00);
      chk_pend("row0_pend", 1'b1);
      step(0, 0, 0, 1, 1, 6'h00);
      step(0, 0, 1, 1, 0, 6'h3F);
      chk_pend("row0_pend_clr", 1'b0);
      step(1, 0, 1, 1, 0, 6'h00);
      step(8, 0, 0, 1, 0, 6'h3F);
      step(0, 8, 0, 0, 0, 6'h3F);
      step(7, 7, 1, 0, 0, 6'h00);

      // blank kills colour, syncs pass
      step(0, 0, 1, 0, 1, 6'h00);
      step(0, 0, 0, 1, 1, 6'h00);
      step(0, 0, 1, 1, 1, 6'h00);
      step(0, 0, 0, 0, 1, 6'h00);

      // fg = 03 (upper data bits ignored) waits for the frame edge
      step(0, 0, 0, 0, 0, 6'h3F, 1'b1, 4'd8, 8'hC3);
      step(0, 0, 1, 0, 0, 6'h3F);
      chk_pend("fg03_pend", 1'b1);
      step(0, 0, 0, 0, 0, 6'h3F);
      step(0, 0, 0, 1, 1, 6'h00);
      step(0, 0, 1, 1, 0, 6'h03);
      chk_pend("fg03_pend_clr", 1'b0);
      step(0, 0, 0, 0, 0, 6'h03);

      // write on the exact frame-edge cycle: copy uses older shadow, pending stays
      step(0, 0, 0, 0, 0, 6'h03, 1'b1, 4'd8, 8'h0C);
      step(0, 0, 0, 0, 0, 6'h03);
      chk_pend("edge_wr_pre", 1'b1);
      step(0, 0, 0, 1, 1, 6'h00, 1'b1, 4'd8, 8'h30);
      step(0, 0, 0, 1, 0, 6'h0C);
      chk_pend("edge_wr_stay", 1'b1);
      step(0, 0, 0, 0, 0, 6'h0C);
      step(0, 0, 0, 1, 1, 6'h00);
      step(0, 0, 1, 1, 0, 6'h30);
      chk_pend("edge_wr_clr", 1'b0);

      // invert with row3 = F0, bg = 15
      step(0, 0, 0, 0, 1, 6'h00, 1'b1, 4'd3, 8'hF0);
      step(0, 0, 0, 0, 1, 6'h00, 1'b1, 4'd9, 8'h15);
      step(0, 0, 0, 0, 1, 6'h00, 1'b1, 4'd10, 8'h03);
      step(0, 0, 0, 1, 1, 6'h00);
      step(0, 3, 0, 1, 0, 6'h15);
      step(4, 3, 1, 0, 0, 6'h30);
      step(0, 0, 0, 0, 0, 6'h15);

      // enable off: black, syncs untouched
      step(0, 3, 0, 0, 1, 6'h00, 1'b1, 4'd10, 8'h02);
      step(0, 3, 0, 1, 1, 6'h00);
      step(4, 3, 1, 1, 0, 6'h00);
      step(0, 3, 1, 0, 0, 6'h00);

      // hole address leaves pending clear
      step(0, 0, 0, 0, 0, 6'h00, 1'b1, 4'd12, 8'hFF);
      step(0, 0, 1, 0, 0, 6'h00);
      chk_pend("addr12_pend", 1'b0);

      // pending write then async reset mid-line discards it
      step(0, 0, 1, 0, 0, 6'h00, 1'b1, 4'd8, 8'h05);
      step(0, 0, 1, 0, 0, 6'h00);
      step(0, 0, 1, 0, 0, 6'h00);
      chk_pend("pre_rst_pend", 1'b1);
      chk8("pre_rst_vga", vga_out, 8'h80);
      #2;
      rst_n = 1'b0;
      #1;
      chk8("async_rst_vga", vga_out, 8'h00);
      chk_pend("async_rst_pend", 1'b0);
      exp_q.delete();
      tag_q.delete();
      @(negedge clk);
      rst_n = 1'b1;

      // after reset fg is back to 3F, not the discarded 05
      step(0, 0, 0, 0, 1, 6'h00, 1'b1, 4'd0, 8'h80);
      step(0, 0, 0, 1, 1, 6'h00);
      step(0, 0, 1, 1, 0, 6'h3F);
      step(1, 0, 0, 0, 0, 6'h00);
      step(0, 0, 0, 0, 1, 6'h00);
      step(0, 0, 0, 0, 1, 6'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
